// File: rtl/forward_ctrl_if.sv
// ============================================================================
// Module : forward_ctrl_if
// Brief  : EX/ID hazard-information bundle and forward/stall results
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface forward_ctrl_if #(
  parameter int CNT_W = 32
);
  logic             i_hold;
  logic             i_ex_valid;
  logic             i_flush_ex;
  logic [4:0]       i_ex_rd;
  logic             i_ex_rd_wren;
  logic             i_ex_is_load;
  logic [4:0]       i_ex_rs1;
  logic [4:0]       i_ex_rs2;
  logic [4:0]       i_id_rs1;
  logic [4:0]       i_id_rs2;
  logic             i_id_rs1_used;
  logic             i_id_rs2_used;
  logic [1:0]       o_forward_a;
  logic [1:0]       o_forward_b;
  logic             o_load_use_stall;
  logic [CNT_W-1:0] o_fwd_count;
  logic [CNT_W-1:0] o_stall_count;

  // Pipeline side: supplies stage info, consumes mux selects and stall
  modport master (
    output i_hold, i_ex_valid, i_flush_ex, i_ex_rd, i_ex_rd_wren, i_ex_is_load,
    output i_ex_rs1, i_ex_rs2, i_id_rs1, i_id_rs2, i_id_rs1_used, i_id_rs2_used,
    input  o_forward_a, o_forward_b, o_load_use_stall, o_fwd_count, o_stall_count
  );

  modport slave (
    input  i_hold, i_ex_valid, i_flush_ex, i_ex_rd, i_ex_rd_wren, i_ex_is_load,
    input  i_ex_rs1, i_ex_rs2, i_id_rs1, i_id_rs2, i_id_rs1_used, i_id_rs2_used,
    output o_forward_a, o_forward_b, o_load_use_stall, o_fwd_count, o_stall_count
  );
endinterface

`default_nettype wire

// File: rtl/forward_ctrl.sv
// ============================================================================
// Module : forward_ctrl
// Brief  : EX operand forwarding selects, load-use stall and perf counters
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module forward_ctrl #(
  parameter int CNT_W             = 32,
  parameter int LOAD_FWD_FROM_MEM = 0
) (
  input  wire            i_clk,
  input  wire            i_reset,
  forward_ctrl_if.slave  bus
);

  localparam logic             c_load_fwd = (LOAD_FWD_FROM_MEM != 0);
  localparam logic [CNT_W-1:0] c_one      = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [1:0]       c_sel_rf   = 2'b00;
  localparam logic [1:0]       c_sel_mem  = 2'b01;
  localparam logic [1:0]       c_sel_wb   = 2'b10;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       wren;
    logic       is_load;
  } shadow_t;

  shadow_t          r_mem;
  shadow_t          r_wb;
  logic [CNT_W-1:0] r_fwd_cnt;
  logic [CNT_W-1:0] r_stall_cnt;

  logic       w_mem_ok;
  logic       w_wb_ok;
  logic       w_hit_mem_a, w_hit_mem_b, w_hit_wb_a, w_hit_wb_b;
  logic [1:0] w_sel_a, w_sel_b;
  logic       w_stall;
  logic       w_fwd_any;

  function automatic logic f_dep(input logic [4:0] r, input logic [4:0] rs1,
                                 input logic [4:0] rs2, input logic u1,
                                 input logic u2);
    return (r != 5'd0) && ((u1 && rs1 == r) || (u2 && rs2 == r));
  endfunction

  always_comb begin
    // A load still in MEM has no data yet unless the memory returns it there
    w_mem_ok    = r_mem.valid & r_mem.wren & (r_mem.rd != 5'd0) &
                  (c_load_fwd | ~r_mem.is_load);
    w_wb_ok     = r_wb.valid & r_wb.wren & (r_wb.rd != 5'd0);
    w_hit_mem_a = w_mem_ok & (r_mem.rd == bus.i_ex_rs1);
    w_hit_mem_b = w_mem_ok & (r_mem.rd == bus.i_ex_rs2);
    w_hit_wb_a  = w_wb_ok  & (r_wb.rd  == bus.i_ex_rs1);
    w_hit_wb_b  = w_wb_ok  & (r_wb.rd  == bus.i_ex_rs2);

    w_sel_a = c_sel_rf;
    w_sel_b = c_sel_rf;
    if (bus.i_ex_valid && !i_reset) begin
      w_sel_a = w_hit_mem_a ? c_sel_mem : (w_hit_wb_a ? c_sel_wb : c_sel_rf);
      w_sel_b = w_hit_mem_b ? c_sel_mem : (w_hit_wb_b ? c_sel_wb : c_sel_rf);
    end

    // Flushed EX load never stalls; second term covers the extra WB-only cycle
    w_stall = ~i_reset & (
                (bus.i_ex_valid & ~bus.i_flush_ex & bus.i_ex_is_load &
                 bus.i_ex_rd_wren &
                 f_dep(bus.i_ex_rd, bus.i_id_rs1, bus.i_id_rs2,
                       bus.i_id_rs1_used, bus.i_id_rs2_used)) |
                (~c_load_fwd & r_mem.valid & r_mem.is_load & r_mem.wren &
                 f_dep(r_mem.rd, bus.i_id_rs1, bus.i_id_rs2,
                       bus.i_id_rs1_used, bus.i_id_rs2_used)));

    w_fwd_any = bus.i_ex_valid & ((w_sel_a != c_sel_rf) | (w_sel_b != c_sel_rf));
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_mem       <= '0;
      r_wb        <= '0;
      r_fwd_cnt   <= '0;
      r_stall_cnt <= '0;
    end else if (!bus.i_hold) begin
      r_mem.valid   <= bus.i_ex_valid & ~bus.i_flush_ex;
      r_mem.rd      <= bus.i_ex_rd;
      r_mem.wren    <= bus.i_ex_rd_wren;
      r_mem.is_load <= bus.i_ex_is_load;
      r_wb          <= r_mem;
      if (w_fwd_any && (r_fwd_cnt != '1)) begin
        r_fwd_cnt <= r_fwd_cnt + c_one;
      end
      if (w_stall && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + c_one;
      end
    end
  end

  assign bus.o_forward_a      = w_sel_a;
  assign bus.o_forward_b      = w_sel_b;
  assign bus.o_load_use_stall = w_stall;
  assign bus.o_fwd_count      = r_fwd_cnt;
  assign bus.o_stall_count    = r_stall_cnt;

endmodule

`default_nettype wire

// File: tb/tb_forward_ctrl.sv
// ============================================================================
// Module : tb_forward_ctrl
// Brief  : Directed bench; instance 0 LOAD_FWD_FROM_MEM=0, 1 =1, 2 CNT_W=4
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_forward_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       hold = 1'b0;
  logic       ex_valid = 1'b0, ex_flush = 1'b0, ex_wren = 1'b0, ex_load = 1'b0;
  logic [4:0] ex_rd = '0, ex_rs1 = '0, ex_rs2 = '0;
  logic [4:0] id_rs1 = '0, id_rs2 = '0;
  logic       id_u1 = 1'b0, id_u2 = 1'b0;

  logic [1:0]  fa [3];
  logic [1:0]  fb [3];
  logic        st [3];
  logic [31:0] fc [3];
  logic [31:0] sc [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar k = 0; k < 3; k++) begin : g_dut
    localparam int LFM = (k == 1) ? 1 : 0;
    localparam int CW  = (k == 2) ? 4 : 32;

    forward_ctrl_if #(.CNT_W(CW)) bus ();

    forward_ctrl #(.CNT_W(CW), .LOAD_FWD_FROM_MEM(LFM)) dut (
      .i_clk   (clk),
      .i_reset (rst),
      .bus     (bus)
    );

    assign bus.i_hold        = hold;
    assign bus.i_ex_valid    = ex_valid;
    assign bus.i_flush_ex    = ex_flush;
    assign bus.i_ex_rd       = ex_rd;
    assign bus.i_ex_rd_wren  = ex_wren;
    assign bus.i_ex_is_load  = ex_load;
    assign bus.i_ex_rs1      = ex_rs1;
    assign bus.i_ex_rs2      = ex_rs2;
    assign bus.i_id_rs1      = id_rs1;
    assign bus.i_id_rs2      = id_rs2;
    assign bus.i_id_rs1_used = id_u1;
    assign bus.i_id_rs2_used = id_u2;
    assign fa[k] = bus.o_forward_a;
    assign fb[k] = bus.o_forward_b;
    assign st[k] = bus.o_load_use_stall;
    assign fc[k] = 32'(bus.o_fwd_count);
    assign sc[k] = 32'(bus.o_stall_count);
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic set_ex(input logic v, input logic fl, input logic [4:0] rd,
                        input logic we, input logic ld, input logic [4:0] r1,
                        input logic [4:0] r2);
    ex_valid = v; ex_flush = fl; ex_rd = rd; ex_wren = we; ex_load = ld;
    ex_rs1 = r1; ex_rs2 = r2;
  endtask

  task automatic set_id(input logic [4:0] r1, input logic [4:0] r2,
                        input logic u1, input logic u2);
    id_rs1 = r1; id_rs2 = r2; id_u1 = u1; id_u2 = u2;
  endtask

  // Moves to 1 time unit after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    #1;
    rst = 1'b0;
    #1;
  endtask

  initial begin : timeout
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    // Reset: a would-be load-use hazard is masked while reset is high
    set_ex(1, 0, 3, 1, 1, 3, 3);
    set_id(0, 3, 0, 1);
    #2;
    check("rst_stall", 32'(st[0]), 0);
    check("rst_fa", 32'(fa[0]), 0);
    check("rst_fcnt", fc[0], 0);
    check("rst_scnt", sc[0], 0);
    tick();
    rst = 1'b0;

    // ALU chain: MEM forward on A, then WB forward on B
    tick(); pulse_reset();
    set_ex(1, 0, 5, 1, 0, 1, 2); set_id(0, 0, 0, 0); #1;
    check("alu0_fa", 32'(fa[0]), 0);
    tick(); set_ex(1, 0, 6, 1, 0, 5, 2); #1;
    check("alu1_fa", 32'(fa[0]), 1);
    check("alu1_fb", 32'(fb[0]), 0);
    tick(); set_ex(1, 0, 0, 0, 0, 9, 5); #1;
    check("alu2_fa", 32'(fa[0]), 0);
    check("alu2_fb", 32'(fb[0]), 2);
    tick(); set_ex(0, 0, 0, 0, 0, 0, 0); #1;
    check("alu_fcnt", fc[0], 2);

    // rd=7 in both MEM and WB: youngest (MEM) wins
    tick(); pulse_reset();
    set_ex(1, 0, 7, 1, 0, 0, 0);
    tick(); tick(); set_ex(1, 0, 0, 0, 0, 7, 7); #1;
    check("both_fa", 32'(fa[0]), 1);
    check("both_fb", 32'(fb[0]), 1);
    set_ex(0, 0, 0, 0, 0, 7, 7); #1;
    check("bubble_fa", 32'(fa[0]), 0);
    // Writes to x0 are never forwarded
    tick(); pulse_reset();
    set_ex(1, 0, 0, 1, 0, 0, 0);
    tick(); tick(); set_ex(1, 0, 3, 1, 0, 0, 0); #1;
    check("x0_fa", 32'(fa[0]), 0);
    check("x0_fb", 32'(fb[0]), 0);

    // Load-use, data only in WB: two stall cycles then WB forward
    tick(); pulse_reset();
    set_ex(1, 0, 3, 1, 1, 1, 2); set_id(0, 3, 0, 1); #1;
    check("lu0_stall_c0", 32'(st[0]), 1);
    tick(); set_ex(0, 0, 0, 0, 0, 0, 0); #1;
    check("lu0_stall_c1", 32'(st[0]), 1);
    tick(); set_ex(1, 0, 8, 1, 0, 4, 3); set_id(0, 0, 0, 0); #1;
    check("lu0_stall_c2", 32'(st[0]), 0);
    check("lu0_fb", 32'(fb[0]), 2);
    check("lu0_fa", 32'(fa[0]), 0);
    check("lu0_scnt", sc[0], 2);

    // Load-use, data available in MEM: one stall cycle then MEM forward
    tick(); pulse_reset();
    set_ex(1, 0, 3, 1, 1, 1, 2); set_id(0, 3, 0, 1); #1;
    check("lu1_stall_c0", 32'(st[1]), 1);
    tick(); set_ex(1, 0, 8, 1, 0, 4, 3); set_id(0, 0, 0, 0); #1;
    check("lu1_stall_c1", 32'(st[1]), 0);
    check("lu1_fb", 32'(fb[1]), 1);
    check("lu1_scnt", sc[1], 1);

    // Flushed load: no stall, and its shadow is invalid next cycle
    tick(); pulse_reset();
    set_ex(1, 1, 3, 1, 1, 1, 2); set_id(0, 3, 0, 1); #1;
    check("flush_stall0", 32'(st[0]), 0);
    check("flush_stall1", 32'(st[1]), 0);
    tick(); set_ex(1, 0, 8, 1, 0, 3, 3); set_id(0, 3, 0, 1); #1;
    check("flush_fa1", 32'(fa[1]), 0);
    check("flush_fb1", 32'(fb[1]), 0);
    check("flush_stall_next", 32'(st[0]), 0);

    // Hold for 3 edges: MEM hit stays, counter frozen
    tick(); pulse_reset();
    set_ex(1, 0, 5, 1, 0, 0, 0); set_id(0, 0, 0, 0);
    tick(); hold = 1'b1; set_ex(1, 0, 0, 0, 0, 5, 0); #1;
    check("hold_fa_pre", 32'(fa[0]), 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("hold_fa_%0d", i), 32'(fa[0]), 1);
      check($sformatf("hold_fcnt_%0d", i), fc[0], 0);
    end
    hold = 1'b0;
    tick();
    check("unhold_fa", 32'(fa[0]), 2);
    check("unhold_fcnt", fc[0], 1);

    // Reset pulse mid-stall drops everything in the same cycle
    tick(); pulse_reset();
    set_ex(1, 0, 5, 1, 0, 0, 0);
    tick(); set_ex(1, 0, 3, 1, 1, 5, 0); set_id(0, 3, 0, 1); #1;
    check("mid_fa_pre", 32'(fa[0]), 1);
    check("mid_stall_pre", 32'(st[0]), 1);
    rst = 1'b1; #1;
    check("mid_fa_rst", 32'(fa[0]), 0);
    check("mid_stall_rst", 32'(st[0]), 0);
    rst = 1'b0; #1;
    check("mid_fa_after", 32'(fa[0]), 0);
    check("mid_scnt_after", sc[0], 0);

    // Forward every cycle: 4-bit counter saturates, 32-bit keeps counting
    tick(); pulse_reset();
    set_ex(1, 0, 5, 1, 0, 5, 0); set_id(0, 0, 0, 0);
    for (int i = 1; i <= 21; i++) begin
      tick();
      if (i == 15) check("sat_fcnt_14", fc[2], 14);
    end
    check("sat_fcnt_15", fc[2], 15);
    check("wide_fcnt_20", fc[0], 20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
